// File: rtl/r6_frame_gather.sv
// Radix-6 front end: gathers serial IEEE-754 singles into 6-sample frames,
// flushes tiny exponents to signed zero, and hands frames out through a ping-pong buffer.
module r6_frame_gather #(
    parameter int DW      = 32,
    parameter int N       = 6,
    parameter int EXP_MIN = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DW-1:0]     in_data,
    input  logic              in_valid,
    input  logic              in_sof,
    output logic              in_ready,
    output logic [DW*N-1:0]   out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       frame_cnt,
    output logic              ftz_flag,
    output logic              sync_err,
    input  logic              clr_flags
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [DW-1:0] bank [2][N];
    logic [IW-1:0] idx;
    logic          wr_bank;
    logic          rd_bank;
    logic [1:0]    full;

    logic          wr_en;
    logic          rd_en;
    logic          resync;
    logic          wr_last;
    logic          flush;
    logic          ftz_hit;
    logic [DW-1:0] wr_word;

    // Keeps the sign, zeroes exponent and mantissa so later exponent decrements cannot wrap.
    function automatic logic [DW-1:0] ftz_word(input logic [DW-1:0] x, input logic do_flush);
        logic [DW-1:0] r;
        r = x;
        if (do_flush) begin
            r = '0;
            r[DW-1] = x[DW-1];
        end
        return r;
    endfunction

    assign in_ready  = !full[wr_bank];
    assign wr_en     = in_valid && in_ready;
    assign out_valid = full[rd_bank];
    assign rd_en     = out_valid && out_ready;

    assign resync  = in_sof && (idx != '0);
    assign wr_last = !resync && (idx == IW'(N - 1));
    assign flush   = in_data[30:23] <= 8'(EXP_MIN);
    assign ftz_hit = flush && (in_data[30:0] != 31'd0);
    assign wr_word = ftz_word(in_data, flush);

    always_comb begin
        out_data = '0;
        for (int i = 0; i < N; i++) begin
            out_data[i*DW +: DW] = bank[rd_bank][i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < N; i++) begin
                    bank[b][i] <= '0;
                end
            end
            idx       <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            full      <= 2'b00;
            frame_cnt <= 16'd0;
            ftz_flag  <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            if (wr_en) begin
                // A start-of-frame mid-frame restarts the gather at slot 0.
                if (resync) begin
                    bank[wr_bank][0] <= wr_word;
                    idx              <= IW'(1);
                end else begin
                    bank[wr_bank][idx] <= wr_word;
                    idx                <= wr_last ? '0 : idx + IW'(1);
                end
                if (wr_last) begin
                    wr_bank <= !wr_bank;
                end
            end

            // Completing one bank and releasing the other may happen together.
            for (int b = 0; b < 2; b++) begin
                full[b] <= (full[b] && !(rd_en && (rd_bank == 1'(b))))
                         || (wr_en && wr_last && (wr_bank == 1'(b)));
            end

            if (rd_en) begin
                rd_bank   <= !rd_bank;
                frame_cnt <= frame_cnt + 16'd1;
            end

            ftz_flag <= (wr_en && ftz_hit) || (ftz_flag && !clr_flags);
            sync_err <= (wr_en && resync)  || (sync_err && !clr_flags);
        end
    end

endmodule

// File: tb/tb_r6_frame_gather.sv
// Bench for r6_frame_gather: randomized and directed frames checked against a queue-based model.
module tb_r6_frame_gather;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_sof;
    logic         in_ready;
    logic [191:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  frame_cnt;
    logic         ftz_flag;
    logic         sync_err;
    logic         clr_flags;

    r6_frame_gather dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .frame_cnt(frame_cnt), .ftz_flag(ftz_flag), .sync_err(sync_err),
        .clr_flags(clr_flags)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: partial frame, expected frames, observed frames, counters and flags.
    logic [31:0]  part_q[$];
    logic [191:0] exp_q[$];
    logic [191:0] got_q[$];
    logic [15:0]  m_cnt;
    logic         m_ftz;
    logic         m_sync;
    logic         last_acc;
    logic         last_rdy;

    // One clock: drive inputs at the falling edge, log handshakes, advance the model.
    task automatic step(input logic [31:0] d, input logic v, input logic s, input logic ordy, input logic clr);
        logic [31:0]  w;
        logic [191:0] f;
        logic         set_f;
        logic         set_s;
        int           e;
        @(negedge clk);
        in_data = d; in_valid = v; in_sof = s; out_ready = ordy; clr_flags = clr;
        last_rdy = in_ready;
        last_acc = v && in_ready;
        if (out_valid && ordy) got_q.push_back(out_data);
        set_f = 1'b0;
        set_s = 1'b0;
        if (last_acc) begin
            e = int'((d >> 23) & 32'hFF);
            w = d;
            if (e <= 14) begin
                w = d & 32'h8000_0000;
                set_f = (d & 32'h7FFF_FFFF) != 0;
            end
            if (s && part_q.size() != 0) begin
                part_q.delete();
                set_s = 1'b1;
            end
            part_q.push_back(w);
            if (part_q.size() == 6) begin
                f = '0;
                for (int i = 0; i < 6; i++) f[i*32 +: 32] = part_q[i];
                exp_q.push_back(f);
                part_q.delete();
                m_cnt = m_cnt + 16'd1;
            end
        end
        m_ftz  = set_f || (m_ftz && !clr);
        m_sync = set_s || (m_sync && !clr);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b0; clr_flags = 1'b0;
    endtask

    task automatic idle(input int n, input logic ordy);
        repeat (n) step(32'd0, 1'b0, 1'b0, ordy, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        part_q.delete(); exp_q.delete(); got_q.delete();
        m_cnt = 16'd0; m_ftz = 1'b0; m_sync = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_tests++; if (out_data !== 192'd0) begin n_fail++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        n_tests++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_frame_cnt got=%h want=0", frame_cnt); end
        n_tests++; if (ftz_flag !== 1'b0) begin n_fail++; $display("FAIL reset_ftz_flag got=%b want=0", ftz_flag); end
        n_tests++; if (sync_err !== 1'b0) begin n_fail++; $display("FAIL reset_sync_err got=%b want=0", sync_err); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_basic();
        logic [31:0] vals [6];
        logic        rdy_all;
        vals = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000};
        rdy_all = 1'b1;
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            step(vals[i], 1'b1, (i == 0), 1'b1, 1'b0);
            rdy_all = rdy_all && last_rdy;
            if (i == 4) begin
                n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got=%b want=0", out_valid); end
            end
        end
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency out_valid got=%b want=1", out_valid); end
        n_tests++; if (out_data[31:0] !== 32'h3F80_0000) begin n_fail++; $display("FAIL basic_x0 got=%h want=3f800000", out_data[31:0]); end
        n_tests++; if (out_data[191:160] !== 32'h40C0_0000) begin n_fail++; $display("FAIL basic_x5 got=%h want=40c00000", out_data[191:160]); end
        step(32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        rdy_all = rdy_all && last_rdy;
        n_tests++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL basic_frame_cnt got=%h want=1", frame_cnt); end
        n_tests++; if (rdy_all !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready dropped got=%b want=1", rdy_all); end
        n_tests++; if (got_q.size() != 1 || exp_q.size() != 1) begin n_fail++; $display("FAIL basic_frames got=%0d want=%0d", got_q.size(), exp_q.size()); end
        else begin
            n_tests++; if (got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL basic_frame got=%h want=%h", got_q[0], exp_q[0]); end
        end
    endtask

    task automatic test_ftz();
        logic [31:0]  vals [6];
        logic [191:0] want;
        vals = '{32'h0700_0000, 32'h8780_0000, 32'h8000_0000, 32'h0000_0001, 32'h7F80_0000, 32'h3F80_0000};
        want = {32'h3F80_0000, 32'h7F80_0000, 32'h0000_0000, 32'h8000_0000, 32'h8780_0000, 32'h0000_0000};
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 6; i++) step(vals[i], 1'b1, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b1);
        n_tests++; if (got_q.size() != 1) begin n_fail++; $display("FAIL ftz_frames got=%0d want=1", got_q.size()); end
        else begin
            n_tests++; if (got_q[0] !== want) begin n_fail++; $display("FAIL ftz_frame got=%h want=%h", got_q[0], want); end
        end
        n_tests++; if (ftz_flag !== 1'b1) begin n_fail++; $display("FAIL ftz_flag_set got=%b want=1", ftz_flag); end
        step(32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_tests++; if (ftz_flag !== 1'b0) begin n_fail++; $display("FAIL ftz_flag_clr got=%b want=0", ftz_flag); end
        vals = '{32'h8000_0000, 32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000, 32'h0F00_0000, 32'h3F80_0000};
        for (int i = 0; i < 6; i++) step(vals[i], 1'b1, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b1);
        n_tests++; if (ftz_flag !== 1'b0) begin n_fail++; $display("FAIL ftz_zero_inf_no_flag got=%b want=0", ftz_flag); end
        step(32'h0000_0001, 1'b1, 1'b0, 1'b1, 1'b1);
        n_tests++; if (ftz_flag !== 1'b1) begin n_fail++; $display("FAIL ftz_set_wins got=%b want=1", ftz_flag); end
        step(32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(32'h3F80_0000, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b1);
        n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ftz_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ftz_model_frame%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_sof();
        logic [31:0]  s [9];
        logic [191:0] want;
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 9; i++) s[i] = $urandom() | 32'h4000_0000;
        want = '0;
        for (int k = 0; k < 6; k++) want[k*32 +: 32] = s[3+k];
        for (int i = 0; i < 3; i++) step(s[i], 1'b1, (i == 0), 1'b1, 1'b0);
        n_tests++; if (sync_err !== 1'b0) begin n_fail++; $display("FAIL sof_before got=%b want=0", sync_err); end
        step(s[3], 1'b1, 1'b1, 1'b1, 1'b1);
        n_tests++; if (sync_err !== 1'b1) begin n_fail++; $display("FAIL sof_sync_err got=%b want=1", sync_err); end
        for (int i = 4; i < 9; i++) step(s[i], 1'b1, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b1);
        n_tests++; if (got_q.size() != 1) begin n_fail++; $display("FAIL sof_frames got=%0d want=1", got_q.size()); end
        else begin
            n_tests++; if (got_q[0] !== want) begin n_fail++; $display("FAIL sof_frame got=%h want=%h", got_q[0], want); end
        end
        step(32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_tests++; if (sync_err !== 1'b0) begin n_fail++; $display("FAIL sof_clr got=%b want=0", sync_err); end
    endtask

    task automatic test_back_to_back_stall();
        logic [31:0] more [6];
        int          acc;
        int          k;
        int          budget;
        got_q.delete(); exp_q.delete();
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            step($urandom(), 1'b1, 1'b0, 1'b0, 1'b0);
            if (last_acc) acc++;
            if (i == 10) begin
                n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready_11 got=%b want=1", in_ready); end
            end
        end
        n_tests++; if (acc != 12) begin n_fail++; $display("FAIL stall_accepted got=%0d want=12", acc); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready_12 got=%b want=0", in_ready); end
        for (int i = 0; i < 6; i++) more[i] = $urandom();
        acc = 0;
        repeat (3) begin
            step(more[0], 1'b1, 1'b0, 1'b0, 1'b0);
            if (last_acc) acc++;
        end
        n_tests++; if (acc != 0) begin n_fail++; $display("FAIL stall_blocked got=%0d want=0", acc); end
        k = 0;
        budget = 60;
        while (k < 6 && budget > 0) begin
            step(more[k], 1'b1, 1'b0, 1'b1, 1'b0);
            if (last_acc) k++;
            budget--;
        end
        n_tests++; if (k != 6) begin n_fail++; $display("FAIL stall_resume_timeout got=%0d want=6", k); end
        idle(4, 1'b1);
        n_tests++; if (got_q.size() != 3 || exp_q.size() != 3) begin n_fail++; $display("FAIL stall_count got=%0d want=3", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_frame%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0]  s [6];
        logic [191:0] want;
        for (int i = 0; i < 10; i++) step($urandom(), 1'b1, 1'b0, 1'b0, 1'b0);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_valid got=%b want=1", out_valid); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid got=%b want=0", out_valid); end
        n_tests++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid_frame_cnt got=%h want=0", frame_cnt); end
        do_reset();
        want = '0;
        for (int i = 0; i < 6; i++) begin
            s[i] = $urandom() | 32'h4000_0000;
            want[i*32 +: 32] = s[i];
        end
        idle(2, 1'b1);
        n_tests++; if (got_q.size() != 0) begin n_fail++; $display("FAIL rstmid_stale got=%0d want=0", got_q.size()); end
        for (int i = 0; i < 6; i++) step(s[i], 1'b1, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b1);
        n_tests++; if (got_q.size() != 1) begin n_fail++; $display("FAIL rstmid_frames got=%0d want=1", got_q.size()); end
        else begin
            n_tests++; if (got_q[0] !== want) begin n_fail++; $display("FAIL rstmid_frame got=%h want=%h", got_q[0], want); end
        end
    endtask

    task automatic test_random();
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 600; i++) begin
            step($urandom(), ($urandom_range(3) != 0), ($urandom_range(11) == 0),
                 ($urandom_range(2) != 0), ($urandom_range(19) == 0));
            n_tests++; if (ftz_flag !== m_ftz || sync_err !== m_sync) begin
                n_fail++; $display("FAIL rand_flags cyc=%0d got=%b%b want=%b%b", i, ftz_flag, sync_err, m_ftz, m_sync);
            end
        end
        idle(4, 1'b1);
        n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_frame%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
        n_tests++; if (frame_cnt !== m_cnt) begin n_fail++; $display("FAIL rand_frame_cnt got=%h want=%h", frame_cnt, m_cnt); end
    endtask

    task automatic test_wrap();
        do_reset();
        @(negedge clk);
        force dut.frame_cnt = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.frame_cnt;
        m_cnt = 16'hFFFE;
        n_tests++; if (frame_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_preset got=%h want=fffe", frame_cnt); end
        for (int i = 0; i < 12; i++) step($urandom(), 1'b1, 1'b0, 1'b1, 1'b0);
        idle(3, 1'b1);
        n_tests++; if (frame_cnt !== 16'h0000) begin n_fail++; $display("FAIL wrap_frame_cnt got=%h want=0000", frame_cnt); end
        n_tests++; if (frame_cnt !== m_cnt) begin n_fail++; $display("FAIL wrap_model got=%h want=%h", frame_cnt, m_cnt); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in_data = '0; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b0; clr_flags = 1'b0;
        last_acc = 1'b0; last_rdy = 1'b0;
        test_reset();
        test_basic();
        test_ftz();
        test_sof();
        test_back_to_back_stall();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/r6_frame_gather.md
Name: r6_frame_gather

Overview:
- Front-end stage of the radix-6 datapath; sits directly upstream of the constant-multiplier stages.
- Takes a serial stream of IEEE-754 single-precision samples and groups them into 6-sample frames.
- Flushes small-exponent operands to signed zero so the downstream exponent-decrement scaling (decrements up to 14) cannot wrap.
- Presents each frame in parallel through a ping-pong buffer with valid/ready on both sides.

Parameters:
- DW, 32, sample width (IEEE-754 single precision; the FTZ logic assumes 32).
- N, 6, samples per frame (radix).
- EXP_MIN, 14, any biased exponent <= EXP_MIN is flushed to zero.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  32  serial sample.
- in_valid  input  1  in_data valid.
- in_sof  input  1  start of frame; qualified by an input handshake.
- in_ready  output  1  block can accept a sample.
- out_data  output  192  frame; x0 at [31:0], x5 at [191:160].
- out_valid  output  1  out_data holds a complete frame.
- out_ready  input  1  downstream accepts the frame.
- frame_cnt  output  16  number of frames delivered, wraps.
- ftz_flag  output  1  sticky: at least one sample was flushed.
- sync_err  output  1  sticky: a partial frame was discarded.
- clr_flags  input  1  synchronous clear of ftz_flag and sync_err.

Behaviour:
- Reset (async assert, sync release):
  - Both banks empty, bank contents 0.
  - idx=0, wr_bank=A, rd_bank=A.
  - out_valid=0, out_data=0, frame_cnt=0, ftz_flag=0, sync_err=0.
  - in_ready=1 once rst_n is high.
- Input handshake: in_valid && in_ready.
  - in_ready = !full[wr_bank]; it is combinational from registered full flags only, never from out_ready.
- Write on handshake:
  - The sample is written to bank[wr_bank][idx].
  - If idx==N-1: set full[wr_bank], toggle wr_bank, idx<=0. Otherwise idx<=idx+1.
- FTZ:
  - If in_data[30:23] <= EXP_MIN, the stored word is {in_data[31], 31'b0}.
  - ftz_flag is set if the flushed word had any nonzero bit in [30:0].
  - Signed zeros pass through unchanged without setting the flag.
  - Exponent 255 (Inf/NaN) passes unchanged.
- SOF:
  - in_sof with idx!=0: discard the partial frame, write the sample to slot 0, idx<=1, set sync_err.
  - in_sof with idx==0: normal write.
  - in_sof is not required; frames without it are accepted normally.
- Output side:
  - out_valid = full[rd_bank]; out_data = bank[rd_bank], driven from registers.
  - On out_valid && out_ready: clear full[rd_bank], toggle rd_bank, frame_cnt<=frame_cnt+1 (0xFFFF->0).
- Latency: the 6th sample is accepted in cycle t; out_valid is 1 in cycle t+1.
- Throughput:
  - With out_ready held 1, in_ready never drops: 1 sample/cycle in, 1 frame/6 cycles out.
  - With out_ready held 0, the block accepts exactly 2N samples, then in_ready=0.
- Simultaneous events:
  - A write completing one bank and a read releasing the other bank in the same cycle are both honoured.
  - Filling a bank while the same bank is being released cannot occur, because in_ready gates the fill.
- Flags:
  - clr_flags clears both sticky flags.
  - If a set event occurs in the same cycle as clr_flags, set wins.
- Reset mid-operation: all buffered samples are dropped and no partial frame is emitted after release.

Test Plan:
- Feed samples 1.0..6.0 (0x3F800000, 0x40000000, ...) back-to-back with out_ready=1 -> out_valid pulses 1 cycle after the 6th sample, out_data[31:0]=0x3F800000, out_data[191:160]=0x40C00000, frame_cnt=1, in_ready stays 1.
- Hold out_ready=0 and stream 14 samples -> in_ready falls after the 12th accepted sample. Raise out_ready -> frame A delivered, then frame B, then samples 13-14 complete frame C with no loss or reorder.
- Inputs 0x07000000 (exp 14), 0x87800000 (exp 15), 0x80000000, 0x00000001 -> stored 0x00000000, 0x87800000, 0x80000000, 0x00000000; ftz_flag=1. Pulse clr_flags -> 0.
- 3 samples, then a sample with in_sof=1, then 5 more -> sync_err=1, and the emitted frame is the sof sample plus the next 5.
- Assert rst_n=0 with idx=4 and one bank full -> out_valid=0, frame_cnt=0, and the next 6 samples form a clean frame.
- Run 65536 frames -> frame_cnt wraps to 0x0000.
